alu_operand_sequencer: RTL and testbench

- FSM-driven operand entry stage that sits directly upstream of the 4-op ALU (SUB/ADD/OR/AND, M-bit operands, 5-bit flags {N,Z,C,V,P}).
- User loads A, B, then OpCode from a shared switch bus using an Enter button; the block drives the ALU operand/opcode inputs from registers.
- It also captures the ALU's Result/Flags into display registers.
- An Undo button steps back one entry stage.

---
 rtl/alu_seq_pkg.sv | 33 +++
 rtl/btn_edge_sync.sv | 33 +++
 rtl/alu_operand_sequencer.sv | 129 ++++++++++++
 tb/tb_alu_operand_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU operand sequencer
//
// Contents:
//   state_t        entry-stage state (WAIT_A, WAIT_B, WAIT_OP, SHOW)
//   OP_*           OpCode encodings understood by the downstream ALU
//   FLAG_*         bit positions inside the {N,Z,C,V,P} flags word
//   state_onehot   maps a state to its one-hot LED pattern
package alu_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  localparam logic [1:0] OP_SUB = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_P = 0;

  // Encoding order of state_t matches LED order, so the one-hot is a shift.
  function automatic logic [3:0] state_onehot(input state_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - button synchronizer with single-cycle rising-edge pulse
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   btn_in     debounced button level, asynchronous to clk
//   pulse_out  one-cycle pulse per press, SYNC_STAGES cycles after btn_in rises
module btn_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // High only on the first synchronized cycle of a press; holding gives nothing more.
  assign pulse_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - operand/opcode entry sequencer feeding the 4-op ALU
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   data_in             switch bus: operand value, or OpCode in bits [1:0]
//   enter_btn/undo_btn  debounced button levels, asynchronous to clk
//   alu_result/flags    combinational result and {N,Z,C,V,P} from the ALU
//   op_a/op_b/opcode    registered ALU inputs
//   result_q/flags_q    captured ALU outputs, result_valid while they match op_a/op_b/opcode
//   disp_value          data_in while entering, result_q in SHOW
//   stage_leds          one-hot state: bit0=WAIT_A .. bit3=SHOW
module alu_operand_sequencer #(
  parameter int M           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] data_in,
  input  logic         enter_btn,
  input  logic         undo_btn,
  input  logic [M-1:0] alu_result,
  input  logic [4:0]   alu_flags,
  output logic [M-1:0] op_a,
  output logic [M-1:0] op_b,
  output logic [1:0]   opcode,
  output logic [M-1:0] result_q,
  output logic [4:0]   flags_q,
  output logic         result_valid,
  output logic [M-1:0] disp_value,
  output logic [3:0]   stage_leds
);

  import alu_seq_pkg::*;

  logic enter_pulse;
  logic undo_pulse;
  logic enter_ev;
  logic undo_ev;

  state_t       state_q;
  logic [M-1:0] op_a_q;
  logic [M-1:0] op_b_q;
  logic [1:0]   opcode_q;
  logic [M-1:0] res_q;
  logic [4:0]   flg_q;
  logic         valid_q;

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_enter_sync (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (enter_btn),
    .pulse_out (enter_pulse)
  );

  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_undo_sync (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (undo_btn),
    .pulse_out (undo_pulse)
  );

  // Both buttons in the same cycle is ambiguous, so neither is acted on.
  assign enter_ev = enter_pulse & ~undo_pulse;
  assign undo_ev  = undo_pulse  & ~enter_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      opcode_q <= OP_SUB;
      res_q    <= '0;
      flg_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (enter_ev) begin
            op_a_q  <= data_in;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (enter_ev) begin
            op_b_q  <= data_in;
            state_q <= WAIT_OP;
          end else if (undo_ev) begin
            state_q <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (enter_ev) begin
            opcode_q <= data_in[1:0];
            state_q  <= SHOW;
          end else if (undo_ev) begin
            state_q <= WAIT_B;
          end
        end
        SHOW: begin
          // valid_q is still low on the first SHOW edge: the ALU has had a full
          // cycle on the new operands, so sample once and then hold.
          if (!valid_q) begin
            res_q <= alu_result;
            flg_q <= alu_flags;
          end
          if (enter_ev) begin
            state_q <= WAIT_A;
            valid_q <= 1'b0;
          end else if (undo_ev) begin
            state_q <= WAIT_OP;
            valid_q <= 1'b0;
          end else begin
            valid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign opcode       = opcode_q;
  assign result_q     = res_q;
  assign flags_q      = flg_q;
  assign result_valid = valid_q;
  assign disp_value   = (state_q == SHOW) ? res_q : data_in;
  assign stage_leds   = state_onehot(state_q);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - scoreboard bench for alu_operand_sequencer
module tb_alu_operand_sequencer;

  import alu_seq_pkg::*;

  localparam int M  = 8;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [M-1:0] data_in;
  logic         enter_btn;
  logic         undo_btn;
  logic [M-1:0] alu_result;
  logic [4:0]   alu_flags;
  logic [M-1:0] op_a;
  logic [M-1:0] op_b;
  logic [1:0]   opcode;
  logic [M-1:0] result_q;
  logic [4:0]   flags_q;
  logic         result_valid;
  logic [M-1:0] disp_value;
  logic [3:0]   stage_leds;

  alu_operand_sequencer #(.M(M), .SYNC_STAGES(SS)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .enter_btn    (enter_btn),
    .undo_btn     (undo_btn),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .op_a         (op_a),
    .op_b         (op_b),
    .opcode       (opcode),
    .result_q     (result_q),
    .flags_q      (flags_q),
    .result_valid (result_valid),
    .disp_value   (disp_value),
    .stage_leds   (stage_leds)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU from plain integer arithmetic; returns {result, N,Z,C,V,P}.
  function automatic logic [M+4:0] alu_ref(input logic [M-1:0] a, input logic [M-1:0] b,
                                           input logic [1:0] op);
    int ua, ub, sa, sb, s;
    logic [M-1:0] r;
    logic [4:0]   f;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (M-1))) ? ua - (1 << M) : ua;
    sb = (ub >= (1 << (M-1))) ? ub - (1 << M) : ub;
    f  = '0;
    case (op)
      OP_SUB: begin
        r         = M'(ua - ub);
        s         = sa - sb;
        f[FLAG_C] = (ua < ub);
        f[FLAG_V] = (s > (1 << (M-1)) - 1) || (s < -(1 << (M-1)));
      end
      OP_ADD: begin
        r         = M'(ua + ub);
        s         = sa + sb;
        f[FLAG_C] = (ua + ub) > ((1 << M) - 1);
        f[FLAG_V] = (s > (1 << (M-1)) - 1) || (s < -(1 << (M-1)));
      end
      OP_OR:   r = a | b;
      default: r = a & b;
    endcase
    f[FLAG_N] = r[M-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_P] = ^r;
    return {r, f};
  endfunction

  // Downstream ALU stand-in, driven from the DUT's registered operands.
  always_comb {alu_result, alu_flags} = alu_ref(op_a, op_b, opcode);

  // Abstract model: stage index 0..3 plus the values the user has entered.
  int           m_stage;
  logic [M-1:0] m_a, m_b, m_res;
  logic [1:0]   m_op;
  logic [4:0]   m_flg;
  logic         m_rv;

  typedef struct {
    int           cyc;
    logic [3:0]   leds;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [1:0]   op;
    logic [M-1:0] res;
    logic [4:0]   flg;
    logic         rv;
    logic [M-1:0] disp;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic model_reset();
    m_stage = 0;
    m_a = '0; m_b = '0; m_res = '0; m_op = 2'b00; m_flg = '0; m_rv = 1'b0;
  endtask

  task automatic push_exp(input int c, input logic [M-1:0] d);
    exp_t e;
    e.cyc  = c;
    e.leds = 4'(1 << m_stage);
    e.a    = m_a;
    e.b    = m_b;
    e.op   = m_op;
    e.res  = m_res;
    e.flg  = m_flg;
    e.rv   = m_rv;
    e.disp = (m_stage == 3) ? m_res : d;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp_v);
    end
  endtask

  // Monitor: compares every expectation due at this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        chk("late_expectation", 32'(cyc), 32'(e.cyc));
      end else begin
        chk("stage_leds",   32'(stage_leds),   32'(e.leds));
        chk("op_a",         32'(op_a),         32'(e.a));
        chk("op_b",         32'(op_b),         32'(e.b));
        chk("opcode",       32'(opcode),       32'(e.op));
        chk("result_q",     32'(result_q),     32'(e.res));
        chk("flags_q",      32'(flags_q),      32'(e.flg));
        chk("result_valid", 32'(result_valid), 32'(e.rv));
        chk("disp_value",   32'(disp_value),   32'(e.disp));
      end
    end
  end

  // Called at posedge+2. Buttons rise before edge n+1, so nothing may change
  // by the n+2 check, the new stage shows at n+3, and a capture at n+4.
  task automatic press(input bit e, input bit u, input logic [M-1:0] d, input int hold);
    int  n;
    bit  show_entry;
    n          = cyc;
    show_entry = 1'b0;
    data_in    = d;
    enter_btn  = e;
    undo_btn   = u;
    push_exp(n + 2, d);
    if (e && !u) begin
      case (m_stage)
        0:       begin m_a = d; m_stage = 1; end
        1:       begin m_b = d; m_stage = 2; end
        2:       begin m_op = d[1:0]; m_stage = 3; show_entry = 1'b1; end
        default: begin m_stage = 0; m_rv = 1'b0; end
      endcase
    end else if (u && !e) begin
      case (m_stage)
        0:       m_stage = 0;
        1:       m_stage = 0;
        2:       m_stage = 1;
        default: begin m_stage = 2; m_rv = 1'b0; end
      endcase
    end
    push_exp(n + 3, d);
    if (show_entry) begin
      {m_res, m_flg} = alu_ref(m_a, m_b, m_op);
      m_rv = 1'b1;
      push_exp(n + 4, d);
    end
    // Still held: no second transition.
    push_exp(n + hold + 3, d);
    repeat (hold) @(posedge clk);
    #2;
    enter_btn = 1'b0;
    undo_btn  = 1'b0;
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic reset_mid();
    reset = 1'b1;
    model_reset();
    push_exp(cyc, data_in);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    reset     = 1'b1;
    data_in   = '0;
    enter_btn = 1'b0;
    undo_btn  = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    push_exp(cyc, data_in);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // ADD 7F+01; upper opcode bits set to show they are ignored
    press(1, 0, 8'h7F, 3);
    press(1, 0, 8'h01, 3);
    press(1, 0, 8'hFD, 3);
    press(1, 0, 8'h00, 3);
    // SUB 05-03, then leave SHOW
    press(1, 0, 8'h05, 3);
    press(1, 0, 8'h03, 3);
    press(1, 0, 8'hA4, 3);
    press(1, 0, 8'h11, 3);
    // Undo path
    press(1, 0, 8'h10, 3);
    press(1, 0, 8'h20, 3);
    press(0, 1, 8'h55, 3);
    press(0, 1, 8'h55, 3);
    press(0, 1, 8'h66, 3);
    press(1, 0, 8'h30, 3);
    // Long hold and simultaneous buttons
    press(1, 0, 8'h42, 50);
    press(1, 1, 8'h99, 4);
    // Undo out of SHOW keeps the result but drops valid
    press(1, 0, 8'h02, 3);
    press(0, 1, 8'h77, 3);
    press(1, 0, 8'h03, 3);
    // Reset mid-sequence
    press(1, 0, 8'hC3, 3);
    reset_mid();

    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (i == 30) reset_mid();
      if (r <= 5)      press(1, 0, M'($urandom), int'($urandom_range(3, 8)));
      else if (r <= 8) press(0, 1, M'($urandom), int'($urandom_range(3, 8)));
      else             press(1, 1, M'($urandom), int'($urandom_range(3, 8)));
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
